// File: rtl/fta_io_responder32.sv
// FTA 32-bit bus responder: decodes one address window and serves a bank of
// control (R/W) and status (R/O) registers with one tagged response per request.
package fta_bus_pkg;
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] padr;
        logic [31:0] dat;
        logic [3:0]  cid;
        logic [7:0]  tid;
    } fta_cmd_request32_t;

    typedef struct packed {
        logic [3:0]  cid;
        logic [7:0]  tid;
        logic [3:0]  pri;
        logic        stall;
        logic        next;
        logic        ack;
        logic        rty;
        logic        err;
        logic [31:0] adr;
        logic [31:0] dat;
    } fta_cmd_response32_t;
endpackage

module fta_io_responder32
    import fta_bus_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'hFEE00000,
    parameter int          NREGS       = 8,
    parameter int          NRW         = 4,
    parameter int          WAIT_STATES = 0,
    parameter logic [3:0]  PRI         = 4'd7
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  fta_cmd_request32_t            req,
    output fta_cmd_response32_t           resp,
    output logic [NRW*32-1:0]             reg_o,
    input  logic [(NREGS-NRW)*32-1:0]     stat_i
);
    localparam int IW      = $clog2(NREGS);
    localparam int ADR_LSB = IW + 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_wc;
    logic           r_we;
    logic [3:0]     r_sel;
    logic [31:0]    r_dat;
    logic [IW-1:0]  r_idx;
    logic [3:0]     r_cid;
    logic [7:0]     r_tid;
    logic [31:0]    r_adr;
    logic [31:0]    r_ctrl [NRW];

    logic           w_hit;
    logic           w_is_rw;
    logic [31:0]    w_words [NREGS];
    logic [31:0]    w_rdat;

    assign w_hit   = req.cyc & req.stb & (req.padr[31:ADR_LSB] == BASE[31:ADR_LSB]);
    assign w_is_rw = (32'(r_idx) < 32'(NRW));
    assign w_rdat  = w_words[r_idx];

    // Flat read view: control registers first, then status words.
    genvar gi;
    for (gi = 0; gi < NREGS; gi++) begin : g_words
        if (gi < NRW) begin : g_rw
            assign w_words[gi]      = r_ctrl[gi];
            assign reg_o[gi*32+:32] = r_ctrl[gi];
        end else begin : g_ro
            assign w_words[gi] = stat_i[(gi-NRW)*32+:32];
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_hit) w_state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
            S_WAIT: if (r_wc == 4'd1) w_state_next = S_ACK;
            S_ACK:  w_state_next = S_DONE;
            // Hold off until the master retires or retags, so a held request is served once.
            S_DONE: if (!req.cyc || (req.tid != r_tid)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            resp    <= '0;
            r_wc    <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_idx   <= '0;
            r_cid   <= '0;
            r_tid   <= '0;
            r_adr   <= '0;
            for (int k = 0; k < NRW; k++) r_ctrl[k] <= '0;
        end else begin
            r_state    <= w_state_next;
            resp       <= '0;
            resp.stall <= (r_state != S_IDLE) && w_hit;

            if (r_state == S_IDLE && w_hit) begin
                r_we  <= req.we;
                r_sel <= req.sel;
                r_dat <= req.dat;
                r_idx <= req.padr[ADR_LSB-1:2];
                r_cid <= req.cid;
                r_tid <= req.tid;
                r_adr <= req.padr;
                r_wc  <= 4'(WAIT_STATES);
            end

            if (r_state == S_WAIT) r_wc <= r_wc - 4'd1;

            if (r_state == S_ACK) begin
                resp.ack <= 1'b1;
                resp.cid <= r_cid;
                resp.tid <= r_tid;
                resp.adr <= r_adr;
                resp.pri <= PRI;
                resp.dat <= r_we ? 32'd0 : w_rdat;
                resp.err <= r_we && !w_is_rw;
                if (r_we && w_is_rw) begin
                    for (int k = 0; k < NRW; k++)
                        for (int b = 0; b < 4; b++)
                            if (r_idx == IW'(k) && r_sel[b])
                                r_ctrl[k][8*b+:8] <= r_dat[8*b+:8];
                end
            end
        end
    end
endmodule

// File: tb/tb_fta_io_responder32.sv
// Directed bench for fta_io_responder32: one instance with no wait states,
// one with three, each with its own request and reset.
module tb_fta_io_responder32;
    import fta_bus_pkg::*;

    localparam logic [31:0] BASE = 32'hFEE00000;

    logic                clk_i = 1'b0;
    logic                rst0, rst3;
    fta_cmd_request32_t  req0, req3;
    fta_cmd_response32_t resp0, resp3;
    logic [127:0]        reg_o0, reg_o3;
    logic [127:0]        stat_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    fta_io_responder32 #(.BASE(BASE), .NREGS(8), .NRW(4), .WAIT_STATES(0), .PRI(4'd7)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst0), .req(req0), .resp(resp0), .reg_o(reg_o0), .stat_i(stat_w));

    fta_io_responder32 #(.BASE(BASE), .NREGS(8), .NRW(4), .WAIT_STATES(3), .PRI(4'd7)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst3), .req(req3), .resp(resp3), .reg_o(reg_o3), .stat_i(stat_w));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int d, input fta_cmd_request32_t r);
        if (d == 0) req0 = r;
        else        req3 = r;
    endtask

    task automatic xfer(input int d, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] cid, input logic [7:0] tid,
                        output int lat, output fta_cmd_response32_t r,
                        output logic ack_next);
        fta_cmd_request32_t  q;
        fta_cmd_response32_t cur;
        q      = '0;
        q.cyc  = 1'b1;
        q.stb  = 1'b1;
        q.we   = we;
        q.sel  = sel;
        q.padr = adr;
        q.dat  = dat;
        q.cid  = cid;
        q.tid  = tid;
        set_req(d, q);
        lat      = -1;
        r        = '0;
        ack_next = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            cur = (d == 0) ? resp0 : resp3;
            if (cur.ack) begin
                lat = n - 1;
                r   = cur;
                break;
            end
        end
        set_req(d, '0);
        tick();
        cur      = (d == 0) ? resp0 : resp3;
        ack_next = cur.ack;
        tick();
        $display("xfer dut%0d we=%0b adr=%h sel=%h cid=%0d tid=%0d lat=%0d ack=%0b err=%0b dat=%h",
                 d, we, adr, sel, r.cid, r.tid, lat, r.ack, r.err, r.dat);
    endtask

    initial begin
        int                  lat;
        int                  acks;
        int                  stalls;
        fta_cmd_response32_t r;
        fta_cmd_request32_t  q;
        logic                an;

        req0   = '0;
        req3   = '0;
        rst0   = 1'b1;
        rst3   = 1'b1;
        stat_w = {32'hCAFEF00D, 32'h0BADF00D, 32'h87654321, 32'h12345678};
        repeat (3) tick();
        rst0 = 1'b0;
        rst3 = 1'b0;
        tick();
        chk("rst_resp0", 64'(|resp0), 64'd0);
        chk("rst_resp3", 64'(|resp3), 64'd0);
        chk("rst_reg_lo", reg_o0[63:0], 64'd0);
        chk("rst_reg_hi", reg_o0[127:64], 64'd0);

        // Full-word write to reg 1
        xfer(0, 1'b1, 4'hF, BASE + 32'd4, 32'hDEADBEEF, 4'd2, 8'd5, lat, r, an);
        chk("wr_lat", 64'(lat), 64'd1);
        chk("wr_tid", 64'(r.tid), 64'd5);
        chk("wr_err", 64'(r.err), 64'd0);
        chk("wr_pri", 64'(r.pri), 64'd7);
        chk("wr_dat", 64'(r.dat), 64'd0);
        chk("wr_ack_one_cycle", 64'(an), 64'd0);
        chk("wr_reg1", 64'(reg_o0[63:32]), 64'hDEADBEEF);

        // Byte-lane write, then read back
        xfer(0, 1'b1, 4'b0100, BASE + 32'd4, 32'h00AA0000, 4'd2, 8'd6, lat, r, an);
        chk("bw_reg1", 64'(reg_o0[63:32]), 64'hDEAABEEF);
        xfer(0, 1'b0, 4'hF, BASE + 32'd4, 32'd0, 4'd3, 8'd9, lat, r, an);
        chk("rd_dat", 64'(r.dat), 64'hDEAABEEF);
        chk("rd_cid", 64'(r.cid), 64'd3);
        chk("rd_tid", 64'(r.tid), 64'd9);
        chk("rd_adr", 64'(r.adr), 64'(BASE + 32'd4));
        chk("rd_err", 64'(r.err), 64'd0);

        // Status read with three wait states
        xfer(3, 1'b0, 4'hF, BASE + 32'd16, 32'd0, 4'd1, 8'd11, lat, r, an);
        chk("ws3_lat", 64'(lat), 64'd4);
        chk("ws3_dat", 64'(r.dat), 64'h12345678);

        // Write to a read-only index
        xfer(0, 1'b1, 4'hF, BASE + 32'd16, 32'hFFFFFFFF, 4'd0, 8'd12, lat, r, an);
        chk("ro_lat", 64'(lat), 64'd1);
        chk("ro_err", 64'(r.err), 64'd1);
        chk("ro_reg_lo", reg_o0[63:0], 64'hDEAABEEF00000000);
        chk("ro_reg_hi", reg_o0[127:64], 64'd0);
        xfer(0, 1'b0, 4'hF, BASE + 32'd16, 32'd0, 4'd0, 8'd13, lat, r, an);
        chk("ro_readback", 64'(r.dat), 64'h12345678);
        xfer(0, 1'b0, 4'hF, BASE + 32'd28, 32'd0, 4'd0, 8'd14, lat, r, an);
        chk("stat3_read", 64'(r.dat), 64'hCAFEF00D);

        // Write with no lanes selected
        xfer(0, 1'b1, 4'h0, BASE + 32'd4, 32'hFFFFFFFF, 4'd0, 8'd15, lat, r, an);
        chk("sel0_lat", 64'(lat), 64'd1);
        chk("sel0_err", 64'(r.err), 64'd0);
        chk("sel0_reg1", 64'(reg_o0[63:32]), 64'hDEAABEEF);

        // Request held with constant tid, then retagged
        q      = '0;
        q.cyc  = 1'b1;
        q.stb  = 1'b1;
        q.padr = BASE + 32'd8;
        q.sel  = 4'hF;
        q.tid  = 8'd20;
        req0   = q;
        acks   = 0;
        stalls = 0;
        repeat (10) begin
            tick();
            acks   += int'(resp0.ack);
            stalls += int'(resp0.stall);
        end
        $display("held tid=20 acks=%0d stalls=%0d", acks, stalls);
        chk("held_acks", 64'(acks), 64'd1);
        chk("held_stall_seen", 64'(stalls > 0), 64'd1);
        q.tid = 8'd21;
        req0  = q;
        acks  = 0;
        repeat (10) begin
            tick();
            acks += int'(resp0.ack);
        end
        $display("held tid=21 acks=%0d", acks);
        chk("retag_acks", 64'(acks), 64'd1);
        req0 = '0;
        repeat (2) tick();

        // Reset while a write is waiting
        q      = '0;
        q.cyc  = 1'b1;
        q.stb  = 1'b1;
        q.we   = 1'b1;
        q.sel  = 4'hF;
        q.padr = BASE + 32'd8;
        q.dat  = 32'h5555AAAA;
        q.tid  = 8'd1;
        req3   = q;
        tick();
        tick();
        rst3 = 1'b1;
        req3 = '0;
        tick();
        rst3 = 1'b0;
        acks = 0;
        repeat (8) begin
            tick();
            acks += int'(resp3.ack);
        end
        $display("reset-in-wait acks=%0d reg2=%h", acks, reg_o3[95:64]);
        chk("rstw_acks", 64'(acks), 64'd0);
        chk("rstw_resp", 64'(|resp3), 64'd0);
        chk("rstw_reg2", 64'(reg_o3[95:64]), 64'd0);
        xfer(3, 1'b0, 4'hF, BASE + 32'd8, 32'd0, 4'd2, 8'd2, lat, r, an);
        chk("rstw_recover_lat", 64'(lat), 64'd4);
        chk("rstw_recover_dat", 64'(r.dat), 64'd0);

        // Miss just past the window
        q      = '0;
        q.cyc  = 1'b1;
        q.stb  = 1'b1;
        q.padr = BASE + 32'd32;
        q.sel  = 4'hF;
        q.tid  = 8'd30;
        req0   = q;
        acks   = 0;
        stalls = 0;
        repeat (5) begin
            tick();
            acks   += int'(resp0.ack);
            stalls += int'(resp0.stall);
        end
        req0 = '0;
        $display("miss adr=%h acks=%0d stalls=%0d", BASE + 32'd32, acks, stalls);
        chk("miss_acks", 64'(acks), 64'd0);
        chk("miss_stalls", 64'(stalls), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
